// File: rtl/pb_io_hub.sv
// pb_io_hub: PicoBlaze I/O port hub.
// Decodes N_IN input ports and N_OUT output ports, registers the in_port read
// mux, produces per-port read-ack / write-enable pulses, and captures rising
// edges on event sources into a pending register that drives a masked
// interrupt request with a request/ack handshake.
//
// Ports:
//   clk, pb_reset        clock, asynchronous active-high reset
//   port_id              PicoBlaze port address
//   read_strobe          PicoBlaze read strobe
//   write_strobe         PicoBlaze write strobe
//   out_port             PicoBlaze write data
//   interrupt_ack        PicoBlaze interrupt acknowledge
//   in_port              registered read data to PicoBlaze
//   interrupt            interrupt request to PicoBlaze
//   in_data              input port bytes, port i = in_data[8i+7:8i]
//   rd_ack               one-cycle read acknowledge per input port
//   event_in             level event sources
//   out_data             held output port bytes, port j = out_data[8j+7:8j]
//   wr_en                one-cycle write pulse per output port
module pb_io_hub #(
    parameter int unsigned N_IN      = 8,
    parameter int unsigned N_OUT     = 4,
    parameter logic [7:0]  IN_BASE   = 8'h00,
    parameter logic [7:0]  OUT_BASE  = 8'h10,
    parameter logic [7:0]  STAT_PORT = 8'hF0,
    parameter logic [7:0]  MASK_PORT = 8'hF1,
    parameter logic [7:0]  ACK_PORTS = 8'h04
) (
    input  logic                 clk,
    input  logic                 pb_reset,
    input  logic [7:0]           port_id,
    input  logic                 read_strobe,
    input  logic                 write_strobe,
    input  logic [7:0]           out_port,
    input  logic                 interrupt_ack,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic [N_IN*8-1:0]    in_data,
    output logic [N_IN-1:0]      rd_ack,
    input  logic [N_IN-1:0]      event_in,
    output logic [N_OUT*8-1:0]   out_data,
    output logic [N_OUT-1:0]     wr_en
);

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACKED  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_d;
    logic                interrupt_d;

    logic [N_IN-1:0]     mask;
    logic [N_IN-1:0]     pending;
    logic [N_IN-1:0]     edge_prev;

    logic                stat_hit_c;
    logic                mask_hit_c;
    logic [N_IN-1:0]     in_hit_c;
    logic [N_OUT-1:0]    out_hit_c;
    logic [BYTE_W-1:0]   rd_data_c;
    logic [N_IN-1:0]     rise_c;
    logic [N_IN-1:0]     w1c_c;
    logic [N_IN-1:0]     pending_d;
    logic                stat_wr_c;
    logic                irq_c;

    // Address decode for the status/mask registers and the port windows.
    always_comb begin
        stat_hit_c = (port_id == STAT_PORT);
        mask_hit_c = (port_id == MASK_PORT);
        in_hit_c   = '0;
        out_hit_c  = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_hit_c[i] = (port_id == (IN_BASE + 8'(i)));
        end
        for (int j = 0; j < N_OUT; j++) begin
            out_hit_c[j] = (port_id == (OUT_BASE + 8'(j)));
        end
    end

    // Read mux; status and mask registers shadow any overlapping input port.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_hit_c[i]) begin
                rd_data_c = in_data[i*BYTE_W +: BYTE_W];
            end
        end
        if (mask_hit_c) begin
            rd_data_c = BYTE_W'(mask);
        end
        if (stat_hit_c) begin
            rd_data_c = BYTE_W'(pending);
        end
    end

    // Edge capture; a new rising edge beats a simultaneous write-1-to-clear.
    always_comb begin
        stat_wr_c = write_strobe & stat_hit_c;
        rise_c    = event_in & ~edge_prev;
        w1c_c     = stat_wr_c ? out_port[N_IN-1:0] : '0;
        pending_d = (pending & ~w1c_c) | rise_c;
        irq_c     = |(pending & mask);
    end

    // Interrupt FSM: next state and the registered interrupt value.
    always_comb begin
        state_d     = state;
        interrupt_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (irq_c) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (interrupt_ack) begin
                    state_d = ST_ACKED;
                end else if (!irq_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACKED: begin
                if (stat_wr_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registering the next-state decode keeps interrupt aligned with ASSERT.
        interrupt_d = (state_d == ST_ASSERT);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_d;
            interrupt <= interrupt_d;
        end
    end

    // Read path: registered in_port and read-ack pulses.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            in_port <= '0;
            rd_ack  <= '0;
        end else begin
            in_port <= rd_data_c;
            rd_ack  <= read_strobe ? (in_hit_c & ACK_PORTS[N_IN-1:0]) : '0;
        end
    end

    // Write path: held output registers and one-cycle write pulses.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            out_data <= '0;
            wr_en    <= '0;
        end else begin
            wr_en <= write_strobe ? out_hit_c : '0;
            for (int j = 0; j < N_OUT; j++) begin
                if (write_strobe && out_hit_c[j]) begin
                    out_data[j*BYTE_W +: BYTE_W] <= out_port;
                end
            end
        end
    end

    // Event registers; edge_prev resets high so sources already high at
    // reset release do not look like fresh edges.
    always_ff @(posedge clk or posedge pb_reset) begin
        if (pb_reset) begin
            mask      <= '0;
            pending   <= '0;
            edge_prev <= '1;
        end else begin
            if (write_strobe && mask_hit_c) begin
                mask <= out_port[N_IN-1:0];
            end
            pending   <= pending_d;
            edge_prev <= event_in;
        end
    end

endmodule
